// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 message path: message geometry, the RAM
// writer state encoding and the plaintext character bounds used by the
// key search to judge a decrypted byte.
package rc4_pkg;

    localparam int MSG_LEN = 32;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wr_state_e;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;

endpackage

// File: rtl/write_ram_mem_if.sv
// Write port of the single-port message RAM. The writer drives it through
// the master modport; the RAM (or a bench model of it) observes it through
// the slave modport.
interface write_ram_mem_if
    import rc4_pkg::*;
#(
    parameter int DATA_W = BYTE_W,
    parameter int ADDR_W = 5
);

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;

    modport master (
        output ram_address,
        output ram_data,
        output ram_wren
    );

    modport slave (
        input ram_address,
        input ram_data,
        input ram_wren
    );

endinterface

// File: rtl/char_checker.sv
// Plaintext character test: a byte is acceptable if it is a space or a
// lowercase ASCII letter. Purely combinational so it can be shared by the
// RAM writer and the key-search logic.
module char_checker
    import rc4_pkg::*;
#(
    parameter int DATA_W = BYTE_W
) (
    input  logic [DATA_W-1:0] data_i,
    output logic              is_valid
);

    assign is_valid = (data_i == DATA_W'(CHAR_SPACE)) ||
                      ((data_i >= DATA_W'(CHAR_LO)) && (data_i <= DATA_W'(CHAR_HI)));

endmodule

// File: rtl/write_ram_mem.sv
// Sequential writer that copies a DEPTH-byte message snapshot into the
// decrypted-message RAM, one byte per clock, starting on a rising edge of
// start. Optional plaintext checking is enabled by defining the macro
// WRITE_RAM_CHECK_EN; without it msg_valid simply follows done and
// bad_index is tied to zero.
module write_ram_mem
    import rc4_pkg::*;
#(
    parameter int DATA_W = BYTE_W,
    parameter int DEPTH  = MSG_LEN,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [DEPTH*DATA_W-1:0] data_in,
    write_ram_mem_if.master         ram,
    output logic                    busy,
    output logic                    done,
    output logic                    msg_valid,
    output logic [ADDR_W-1:0]       bad_index
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              start_dly_q;
    logic [DATA_W-1:0] buf_q [DEPTH];
    logic [DATA_W-1:0] cur_byte;
    logic              start_rise;
    logic              accept;
    logic              in_write;

    assign start_rise = start & ~start_dly_q;
    assign accept     = start_rise && (state_q != WRITE);
    assign in_write   = (state_q == WRITE);
    assign cur_byte   = buf_q[idx_q];

    // Next-state and index sequencing; start edges during WRITE are ignored.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    state_d = WRITE;
                    idx_d   = '0;
                end
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, byte index and start-edge history registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            start_dly_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            start_dly_q <= start;
        end
    end

    // Snapshot the message when a transfer is accepted so later data_in changes are harmless.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ram.ram_wren    = in_write;
    assign ram.ram_address = in_write ? idx_q : '0;
    assign ram.ram_data    = in_write ? cur_byte : '0;
    assign busy            = in_write;
    assign done            = (state_q == DONE);

`ifdef WRITE_RAM_CHECK_EN
    logic              byte_ok;
    logic              msg_valid_q;
    logic [ADDR_W-1:0] bad_index_q;

    char_checker #(
        .DATA_W (DATA_W)
    ) u_char_checker (
        .data_i   (cur_byte),
        .is_valid (byte_ok)
    );

    // Track validity of the transfer; only the first failing index is remembered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_valid_q <= 1'b0;
            bad_index_q <= '0;
        end else if (accept) begin
            msg_valid_q <= 1'b1;
            bad_index_q <= '0;
        end else if (in_write && msg_valid_q && !byte_ok) begin
            msg_valid_q <= 1'b0;
            bad_index_q <= idx_q;
        end
    end

    assign msg_valid = msg_valid_q;
    assign bad_index = bad_index_q;
`else
    assign msg_valid = (state_q == DONE);
    assign bad_index = '0;
`endif

endmodule
